mic_sample_fifo: RTL and testbench
==================================

Name: mic_sample_fifo

Overview:
- Downstream stage of the microphone CIC decimator.
- Captures each decimated 32-bit sample on its one-cycle valid pulse and tags it with a free-running 32-bit clock-cycle timestamp, for inter-microphone arrival-time comparison.
- Buffers sample/timestamp pairs in a first-word-fall-through FIFO with a valid/ready read port for the bus/processor side.
- Reports fill level, sticky overflow and a saturating dropped-sample count.

Parameters:
DATA_W, 32, sample width (matches CIC output)
TS_W, 32, timestamp width
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries)

Ports:
clk  input  1  system clock, 50 MHz, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
in_data  input  DATA_W  sample from CIC data_out
in_valid  input  1  one-cycle strobe from CIC data_out_valid
clear  input  1  synchronous flush
out_data  output  DATA_W  head-of-FIFO sample
out_ts  output  TS_W  head-of-FIFO timestamp
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle
level  output  DEPTH_LOG2+1  current entry count, 0..2^DEPTH_LOG2
overflow  output  1  sticky: at least one sample dropped
drop_cnt  output  16  dropped samples, saturates at 16'hFFFF

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr, level, ts_cnt = 0.
  - overflow = 0, drop_cnt = 0, out_valid = 0.
  - out_data and out_ts = 0; FIFO RAM contents are don't-care.
  - Deassertion is sampled synchronously; the first push is possible on the first edge with rst=1.
- Timestamp counter:
  - ts_cnt increments every clk and wraps from 2^TS_W-1 to 0.
  - A pushed entry stores the ts_cnt value present in the cycle in which in_valid=1 is sampled.
- Push: in_valid=1 at an edge.
  - If not full, or a pop occurs in the same cycle: write {in_data, ts_cnt} at wr_ptr, wr_ptr+1.
  - If full with no simultaneous pop: sample is dropped, overflow<=1, drop_cnt<=drop_cnt+1 (saturating); pointers unchanged.
- Pop: out_valid && out_ready at an edge → rd_ptr+1. When empty, out_ready is ignored.
- FWFT timing:
  - out_valid = (level != 0).
  - out_data/out_ts present the entry at rd_ptr in the same cycle out_valid is high; these are registered outputs.
  - Latency: a push at edge N into an empty FIFO gives out_valid=1 with the data after edge N.
  - After a pop, the next entry (if any) is presented after the same edge.
- Pointer and level arithmetic:
  - Pointers are DEPTH_LOG2+1 bits; full when MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - level = wr_ptr - rd_ptr, computed modulo 2^(DEPTH_LOG2+1).
- Simultaneous push and pop:
  - Empty FIFO: no pop; push accepted; level becomes 1.
  - Full FIFO: both occur; level stays full; overflow is not set.
  - Otherwise: both occur; level unchanged.
- Clear (clear=1 at an edge):
  - wr_ptr = rd_ptr = 0, overflow = 0, drop_cnt = 0, out_valid = 0.
  - ts_cnt is not affected.
  - Clear has priority: a push or pop in the same cycle is discarded and not counted as a drop.
- Drop counter: once drop_cnt = 16'hFFFF it holds; overflow stays 1.
- The block asserts no back-pressure on the CIC side (there is no in_ready); the CIC cannot stall.
- Reset asserted mid-operation: all state clears immediately and asynchronously; any pending output entry is lost.

Test Plan:
- Reset, then push 3 samples (0x11, 0x22, 0x33) at cycles 10, 60, 110 with out_ready=0 → level=3; out_data=0x11 with out_ts=10 (after reset release at cycle 0); popping gives 0x22/60, then 0x33/110.
- Push 16 samples with out_ready=0, then a 17th → level=16, overflow=1, drop_cnt=1. Drain all 16 → data in order, 17th absent, out_valid=0 afterwards.
- With the FIFO full, push and pop in the same cycle → level stays 16, overflow=0, pushed sample appears as the last entry.
- With the FIFO empty, in_valid=1 and out_ready=1 in the same cycle → level=1; entry still present next cycle.
- Apply clear in the same cycle as a push with level=5 and overflow=1 → level=0, overflow=0, drop_cnt=0, out_valid=0; ts_cnt continues without a break.
- Assert rst=0 mid-stream while level=7 → all outputs return to 0 immediately (asynchronously, before the next clk edge); drop_cnt saturation check: force 65536 drops → drop_cnt=16'hFFFF.

Source files
------------

// File: rtl/mic_sample_fifo_if.sv
// Stream bundle between the CIC capture side, the FIFO and the bus-side consumer.
interface mic_sample_fifo_if #(
    parameter int DATA_W = 32,
    parameter int TS_W   = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, out_ts, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, out_ts, out_valid
    );
endinterface

// File: rtl/mic_sample_fifo.sv
// Timestamps each decimated microphone sample and buffers it in a FWFT FIFO.
module mic_sample_fifo #(
    parameter int DATA_W     = 32,
    parameter int TS_W       = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    mic_sample_fifo_if.slave    bus,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow,
    output logic [15:0]         drop_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = DATA_W + TS_W;

    logic [ENT_W-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [TS_W-1:0]     ts_cnt;
    logic                full, do_pop, do_push, do_drop, nxt_nonempty;
    logic [ENT_W-1:0]    wr_ent, head_nxt;

    always_comb begin
        full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
        do_pop  = bus.out_valid && bus.out_ready && !clear;
        do_push = bus.in_valid && !clear && (!full || do_pop);
        do_drop = bus.in_valid && !clear && full && !do_pop;
        wr_ent  = {bus.in_data, ts_cnt};
        rd_nxt  = rd_ptr + {{DEPTH_LOG2{1'b0}}, do_pop};
        wr_nxt  = wr_ptr + {{DEPTH_LOG2{1'b0}}, do_push};
        nxt_nonempty = (wr_nxt != rd_nxt);
        // The next head is the entry being written this cycle when it lands exactly at the new read pointer.
        head_nxt = (do_push && (rd_nxt == wr_ptr)) ? wr_ent
                                                   : mem[rd_nxt[DEPTH_LOG2-1:0]];
    end

    assign level = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_ent;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            overflow      <= 1'b0;
            drop_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ts    <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (clear) begin
                wr_ptr        <= '0;
                rd_ptr        <= '0;
                overflow      <= 1'b0;
                drop_cnt      <= '0;
                bus.out_valid <= 1'b0;
                bus.out_data  <= '0;
                bus.out_ts    <= '0;
            end else begin
                wr_ptr <= wr_nxt;
                rd_ptr <= rd_nxt;
                if (do_drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
                bus.out_valid <= nxt_nonempty;
                if (nxt_nonempty) begin
                    {bus.out_data, bus.out_ts} <= head_nxt;
                end else begin
                    bus.out_data <= '0;
                    bus.out_ts   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Scoreboard bench for mic_sample_fifo: expected entries queued on push, compared at the head.
module tb_mic_sample_fifo;
    localparam int DATA_W     = 32;
    localparam int TS_W       = 32;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                clear;
    logic [DEPTH_LOG2:0] level;
    logic                overflow;
    logic [15:0]         drop_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] cyc;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] ts;
    } ent_t;

    ent_t        sb[$];
    logic        m_ovf;
    logic [15:0] m_drop;

    mic_sample_fifo_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

    mic_sample_fifo #(
        .DATA_W(DATA_W),
        .TS_W(TS_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .bus(bus),
        .level(level),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference cycle count: value sampled by a push at the coming edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= '0;
        else      cyc <= cyc + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: check outputs, drive inputs, advance model, move to next negedge.
    task automatic step(input logic iv, input logic [31:0] d, input logic rdy,
                        input logic clr, input bit chk);
        bit   pop;
        bit   is_full;
        ent_t e;
        if (chk) begin
            check_eq("level", 64'(level), 64'(sb.size()));
            check_eq("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                check_eq("out_data", 64'(bus.out_data), 64'(sb[0].d));
                check_eq("out_ts", 64'(bus.out_ts), 64'(sb[0].ts));
            end
            check_eq("overflow", 64'(overflow), 64'(m_ovf));
            check_eq("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        end
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        clear         = clr;
        if (clr) begin
            sb.delete();
            m_ovf  = 1'b0;
            m_drop = '0;
        end else begin
            pop     = (sb.size() != 0) && rdy;
            is_full = (sb.size() == DEPTH);
            if (pop) void'(sb.pop_front());
            if (iv) begin
                if (!is_full || pop) begin
                    e.d  = d;
                    e.ts = cyc;
                    sb.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic fill(input int unsigned n, input logic [31:0] base);
        for (int unsigned i = 0; i < n; i++) step(1'b1, base + i, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        clear         = 1'b0;
        m_ovf         = 1'b0;
        m_drop        = '0;
        repeat (2) @(negedge clk);

        check_eq("rst_level", 64'(level), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_data", 64'(bus.out_data), 64'd0);
        check_eq("rst_out_ts", 64'(bus.out_ts), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        rst = 1'b1;

        // Three timestamped samples at cycles 10, 60, 110
        for (int c = 0; c <= 110; c++) begin
            if (c == 10)       step(1'b1, 32'h11, 1'b0, 1'b0, 1'b1);
            else if (c == 60)  step(1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
            else if (c == 110) step(1'b1, 32'h33, 1'b0, 1'b0, 1'b1);
            else               idle();
        end
        check_eq("t1_level", 64'(level), 64'd3);
        check_eq("t1_head_data", 64'(bus.out_data), 64'h11);
        check_eq("t1_head_ts", 64'(bus.out_ts), 64'd10);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("t1_second_data", 64'(bus.out_data), 64'h22);
        check_eq("t1_second_ts", 64'(bus.out_ts), 64'd60);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_eq("t1_third_data", 64'(bus.out_data), 64'h33);
        check_eq("t1_third_ts", 64'(bus.out_ts), 64'd110);
        drain(1);
        idle();

        // Overfill by one
        fill(16, 32'h100);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b1);
        check_eq("t2_level", 64'(level), 64'd16);
        check_eq("t2_overflow", 64'(overflow), 64'd1);
        check_eq("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        drain(16);
        check_eq("t2_empty", 64'(bus.out_valid), 64'd0);
        idle();

        // Clear with a concurrent push, level 5, overflow still set
        fill(5, 32'h200);
        check_eq("t5_pre_level", 64'(level), 64'd5);
        step(1'b1, 32'hBEEF, 1'b0, 1'b1, 1'b1);
        check_eq("t5_level", 64'(level), 64'd0);
        check_eq("t5_overflow", 64'(overflow), 64'd0);
        check_eq("t5_drop_cnt", 64'(drop_cnt), 64'd0);
        check_eq("t5_out_valid", 64'(bus.out_valid), 64'd0);
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b1);
        idle();
        drain(1);

        // Full FIFO: push and pop together
        fill(16, 32'h400);
        step(1'b1, 32'hF00D, 1'b1, 1'b0, 1'b1);
        check_eq("t3_level", 64'(level), 64'd16);
        check_eq("t3_overflow", 64'(overflow), 64'd0);
        drain(15);
        check_eq("t3_last", 64'(bus.out_data), 64'hF00D);
        drain(1);
        idle();

        // Empty FIFO: push with out_ready high
        step(1'b1, 32'h44, 1'b1, 1'b0, 1'b1);
        check_eq("t4_level", 64'(level), 64'd1);
        check_eq("t4_data", 64'(bus.out_data), 64'h44);
        idle();
        check_eq("t4_still", 64'(level), 64'd1);
        drain(1);

        // Asynchronous reset mid-stream at level 7
        fill(7, 32'h500);
        check_eq("t6_pre_level", 64'(level), 64'd7);
        rst = 1'b0;
        #1;
        check_eq("arst_level", 64'(level), 64'd0);
        check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("arst_out_data", 64'(bus.out_data), 64'd0);
        check_eq("arst_out_ts", 64'(bus.out_ts), 64'd0);
        check_eq("arst_overflow", 64'(overflow), 64'd0);
        sb.delete();
        m_ovf  = 1'b0;
        m_drop = '0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h600, 1'b0, 1'b0, 1'b1);
        drain(1);

        // Drop counter saturation
        fill(16, 32'h700);
        for (int unsigned i = 0; i < 65540; i++) step(1'b1, i, 1'b0, 1'b0, 1'b0);
        idle();
        check_eq("sat_drop_cnt", 64'(drop_cnt), 64'hFFFF);
        check_eq("sat_overflow", 64'(overflow), 64'd1);
        drain(16);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
